// File: rtl/ooo_completion_arbiter.sv
// ooo_completion_arbiter
// Collects result completions from NUM_FU functional units, buffers each unit
// in its own small FIFO and drains up to NUM_WB_PORTS of them per cycle into
// registered writeback ports using a rotating round-robin grant.
// Optional macro: OOO_CA_EXC_PRIORITY_EN -- when defined, FIFOs whose head
// carries an exception are granted ahead of all others (still round-robin).
module ooo_completion_arbiter #(
    parameter int NUM_FU       = 4,
    parameter int NUM_WB_PORTS = 2,
    parameter int FIFO_DEPTH   = 2,
    parameter int NUM_CB_ENTRY = 16,
    localparam int IDX_W       = $clog2(NUM_CB_ENTRY),
    localparam int FU_W        = $clog2(NUM_FU)
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           flush,
    input  logic                           wb_stall,
    input  logic [NUM_FU-1:0]              fu_valid,
    output logic [NUM_FU-1:0]              fu_ready,
    input  logic [NUM_FU-1:0]              fu_wen,
    input  logic [NUM_FU-1:0]              fu_exception,
    input  logic [NUM_FU*5-1:0]            fu_rd,
    input  logic [NUM_FU*32-1:0]           fu_wdata,
    input  logic [NUM_FU*32-1:0]           fu_pc,
    input  logic [NUM_FU*IDX_W-1:0]        fu_index,
    output logic [NUM_WB_PORTS-1:0]        wb_valid,
    output logic [NUM_WB_PORTS-1:0]        wb_wen,
    output logic [NUM_WB_PORTS-1:0]        wb_exception,
    output logic [NUM_WB_PORTS*5-1:0]      wb_rd,
    output logic [NUM_WB_PORTS*32-1:0]     wb_wdata,
    output logic [NUM_WB_PORTS*32-1:0]     wb_pc,
    output logic [NUM_WB_PORTS*IDX_W-1:0]  wb_index,
    output logic [NUM_WB_PORTS*FU_W-1:0]   wb_fu_id
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef OOO_CA_EXC_PRIORITY_EN
    localparam int NUM_PASS = 2;
`else
    localparam int NUM_PASS = 1;
`endif

    typedef struct packed {
        logic             wen;
        logic             exc;
        logic [4:0]       rd;
        logic [31:0]      wdata;
        logic [31:0]      pc;
        logic [IDX_W-1:0] index;
    } entry_t;

    entry_t                mem      [NUM_FU][FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr   [NUM_FU];
    logic [PTR_W-1:0]      wr_ptr   [NUM_FU];
    logic [CNT_W-1:0]      count    [NUM_FU];
    entry_t                in_entry [NUM_FU];
    entry_t                head     [NUM_FU];
    logic [NUM_FU-1:0]     push;
    logic [NUM_FU-1:0]     grant;
    logic [NUM_WB_PORTS-1:0] port_valid;
    logic [FU_W-1:0]       port_unit [NUM_WB_PORTS];
    logic [FU_W-1:0]       rr_ptr;
    logic [FU_W-1:0]       rr_next;
    logic                  any_grant;

    // Unpack unit inputs, expose FIFO heads and derive ready/handshake per unit
    always_comb begin
        for (int u = 0; u < NUM_FU; u++) begin
            in_entry[u].wen   = fu_wen[u];
            in_entry[u].exc   = fu_exception[u];
            in_entry[u].rd    = fu_rd[u*5 +: 5];
            in_entry[u].wdata = fu_wdata[u*32 +: 32];
            in_entry[u].pc    = fu_pc[u*32 +: 32];
            in_entry[u].index = fu_index[u*IDX_W +: IDX_W];
            head[u]           = mem[u][rd_ptr[u]];
            fu_ready[u]       = (count[u] != CNT_W'(FIFO_DEPTH));
            push[u]           = fu_valid[u] & fu_ready[u];
        end
    end

    // Round-robin selection: first NUM_WB_PORTS eligible FIFOs from rr_ptr fill ports 0 upward
    always_comb begin
        int   n;
        int   u;
        logic elig;
        n          = 0;
        u          = 0;
        elig       = 1'b0;
        grant      = '0;
        port_valid = '0;
        rr_next    = rr_ptr;
        for (int k = 0; k < NUM_WB_PORTS; k++) begin
            port_unit[k] = '0;
        end
        if (!wb_stall) begin
            for (int pass = 0; pass < NUM_PASS; pass++) begin
                for (int off = 0; off < NUM_FU; off++) begin
                    u = int'(rr_ptr) + off;
                    if (u >= NUM_FU) begin
                        u = u - NUM_FU;
                    end
                    elig = (count[u] != '0) && !grant[u];
`ifdef OOO_CA_EXC_PRIORITY_EN
                    if (pass == 0) begin
                        elig = elig && head[u].exc;
                    end
`endif
                    if (elig && (n < NUM_WB_PORTS)) begin
                        grant[u]      = 1'b1;
                        port_valid[n] = 1'b1;
                        port_unit[n]  = FU_W'(u);
                        rr_next       = (u == NUM_FU - 1) ? '0 : FU_W'(u + 1);
                        n             = n + 1;
                    end
                end
            end
        end
        any_grant = |grant;
    end

    // FIFO pointers and occupancy; flush and reset both empty every FIFO
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            for (int u = 0; u < NUM_FU; u++) begin
                rd_ptr[u] <= '0;
                wr_ptr[u] <= '0;
                count[u]  <= '0;
            end
        end else begin
            for (int u = 0; u < NUM_FU; u++) begin
                if (push[u]) begin
                    wr_ptr[u] <= wr_ptr[u] + PTR_W'(1);
                end
                if (grant[u]) begin
                    rd_ptr[u] <= rd_ptr[u] + PTR_W'(1);
                end
                case ({push[u], grant[u]})
                    2'b10:   count[u] <= count[u] + CNT_W'(1);
                    2'b01:   count[u] <= count[u] - CNT_W'(1);
                    default: count[u] <= count[u];
                endcase
            end
        end
    end

    // FIFO storage; a write during flush lands beyond the reset pointers and is never read
    always_ff @(posedge CLK) begin
        for (int u = 0; u < NUM_FU; u++) begin
            if (push[u]) begin
                mem[u][wr_ptr[u]] <= in_entry[u];
            end
        end
    end

    // Writeback registers and rotating pointer; stall freezes both, flush only clears valids
    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_valid     <= '0;
            wb_wen       <= '0;
            wb_exception <= '0;
            wb_rd        <= '0;
            wb_wdata     <= '0;
            wb_pc        <= '0;
            wb_index     <= '0;
            wb_fu_id     <= '0;
            rr_ptr       <= '0;
        end else if (flush) begin
            wb_valid <= '0;
        end else if (!wb_stall) begin
            for (int k = 0; k < NUM_WB_PORTS; k++) begin
                wb_valid[k] <= port_valid[k];
                if (port_valid[k]) begin
                    wb_wen[k]                   <= head[port_unit[k]].wen;
                    wb_exception[k]             <= head[port_unit[k]].exc;
                    wb_rd[k*5 +: 5]             <= head[port_unit[k]].rd;
                    wb_wdata[k*32 +: 32]        <= head[port_unit[k]].wdata;
                    wb_pc[k*32 +: 32]           <= head[port_unit[k]].pc;
                    wb_index[k*IDX_W +: IDX_W]  <= head[port_unit[k]].index;
                    wb_fu_id[k*FU_W +: FU_W]    <= port_unit[k];
                end
            end
            if (any_grant) begin
                rr_ptr <= rr_next;
            end
        end
    end

endmodule

// File: doc/ooo_completion_arbiter.md
Name: ooo_completion_arbiter

Overview:
- Parametrised successor to the fixed four-unit execute-to-commit completion path.
- Accepts result completions from NUM_FU functional units over valid/ready channels and buffers each unit in its own small FIFO.
- Drains up to NUM_WB_PORTS completions per cycle into the completion buffer through registered writeback ports, using a rotating round-robin grant.
- Sits between the functional units and the commit stage; supports flush and a writeback stall.

Parameters:
- NUM_FU, 4, number of functional-unit completion channels (2..8).
- NUM_WB_PORTS, 2, writeback ports per cycle (1..NUM_FU).
- FIFO_DEPTH, 2, entries per functional-unit FIFO (power of two, >=2).
- NUM_CB_ENTRY, 16, completion-buffer entries; IDX_W = $clog2(NUM_CB_ENTRY).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- flush  in  1  discard all buffered and registered completions.
- wb_stall  in  1  commit cannot accept writeback this cycle.
- fu_valid  in  NUM_FU  per-unit completion valid.
- fu_ready  out  NUM_FU  per-unit FIFO not full.
- fu_wen  in  NUM_FU  result writes a register.
- fu_exception  in  NUM_FU  completion carries an exception.
- fu_rd  in  NUM_FU*5  destination register.
- fu_wdata  in  NUM_FU*32  result data.
- fu_pc  in  NUM_FU*32  instruction pc.
- fu_index  in  NUM_FU*IDX_W  completion-buffer index.
- wb_valid  out  NUM_WB_PORTS  writeback port valid.
- wb_wen, wb_exception  out  NUM_WB_PORTS each  forwarded flags.
- wb_rd  out  NUM_WB_PORTS*5.
- wb_wdata, wb_pc  out  NUM_WB_PORTS*32 each.
- wb_index  out  NUM_WB_PORTS*IDX_W.
- wb_fu_id  out  NUM_WB_PORTS*$clog2(NUM_FU)  source unit.

Behaviour:
- Single clock CLK; RST is synchronous, active-high.
- Reset: all FIFOs empty, rr_ptr=0, every wb_* output 0, fu_ready all 1.
- Enqueue:
  - fu_ready[i] = (count[i] != FIFO_DEPTH).
  - Ready is not relaxed by a same-cycle pop (no bypass).
  - A transfer occurs when fu_valid[i] & fu_ready[i]; the entry is written at that edge.
- Selection (combinational each cycle when !wb_stall):
  - Scan units in order rr_ptr, rr_ptr+1, ... modulo NUM_FU.
  - Grant the first NUM_WB_PORTS non-empty FIFOs.
  - The k-th grant goes to port k, so ports fill from 0 upward with no gaps.
- Pop: each granted FIFO pops its head at the edge. At most one pop per FIFO per cycle. A simultaneous push and pop on the same FIFO keeps count unchanged.
- Writeback registers:
  - Port k loads the granted head fields, wb_valid[k]=1, and wb_fu_id = unit number.
  - Ports not granted load wb_valid=0; their other fields are don't-care but must be held stable.
  - Latency: fu handshake in cycle t gives wb_valid earliest in cycle t+2.
- rr_ptr: after a cycle with at least one grant, rr_ptr = (last granted unit + 1) mod NUM_FU. With zero grants it is unchanged.
- wb_stall=1: no grants, no pops, all wb_* registers hold, rr_ptr holds. Enqueue continues normally.
- flush=1 (priority over stall and enqueue):
  - At the edge, all FIFO counts and pointers reset, wb_valid clears to 0, rr_ptr holds.
  - A handshake in the flush cycle is dropped.
  - fu_ready is all 1 from the next cycle.
- RST mid-operation behaves identically to flush, except rr_ptr is also reset to 0.
- Pointer wrap: each FIFO uses read/write pointers of $clog2(FIFO_DEPTH) bits with a separate count of $clog2(FIFO_DEPTH)+1 bits. Pointers wrap naturally.
- No two ports ever carry the same fu_id in one cycle. Per-unit ordering is preserved.

Optional Feature:
- OOO_CA_EXC_PRIORITY_EN defined:
  - Selection first grants, in round-robin order, FIFOs whose head has exception=1.
  - Remaining ports are then filled by normal round-robin over the other non-empty FIFOs.
  - rr_ptr update uses the last grant made in the combined order.
- Undefined: exception is carried as plain data and has no effect on selection.

Test Plan:
- Reset, then idle -> fu_ready=4'b1111, wb_valid=2'b00, all wb fields 0.
- Single push on unit 2 (rd=5, wdata=0xDEADBEEF, index=3) in cycle 1 -> in cycle 3, wb_valid=2'b01, wb_fu_id[0]=2, wb_rd[0]=5, wb_wdata[0]=0xDEADBEEF; rr_ptr becomes 3.
- All 4 units push one entry each in the same cycle, rr_ptr=0 -> first writeback cycle carries units 0,1; next cycle carries units 2,3; rr_ptr ends at 0.
- Unit 0 pushes 3 back-to-back with wb_stall=1 -> fu_ready[0]=0 after 2 accepts and the third is held. Release stall -> entries drain in push order, one per cycle, from port 0.
- flush asserted with FIFOs full and wb_valid=2'b11 -> next cycle wb_valid=0 and fu_ready=1111. A push made during the flush cycle never appears on wb.
- With OOO_CA_EXC_PRIORITY_EN, rr_ptr=0, units 0,1,3 non-empty, unit 3 head exception=1 -> ports carry units 3 and 0 in that order.
